// File: rtl/credit_display_driver.sv
// Seven-segment driver for the slot machine board: reel glyphs, bet digit and a
// credit balance that counts up one per tick and is converted to BCD serially.
module credit_display_driver #(
  parameter int TICK_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] credits,
  input  logic [3:0] bet,
  input  logic [2:0] symbol_left,
  input  logic [2:0] symbol_right,
  output logic [6:0] hex5,
  output logic [6:0] hex4,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       counting
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [6:0] BLANK = 7'h7F;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 7'h40;
      4'd1:    digit_seg = 7'h79;
      4'd2:    digit_seg = 7'h24;
      4'd3:    digit_seg = 7'h30;
      4'd4:    digit_seg = 7'h19;
      4'd5:    digit_seg = 7'h12;
      4'd6:    digit_seg = 7'h02;
      4'd7:    digit_seg = 7'h78;
      4'd8:    digit_seg = 7'h00;
      4'd9:    digit_seg = 7'h10;
      default: digit_seg = BLANK;
    endcase
  endfunction

  function automatic logic [6:0] glyph(input logic [2:0] s);
    case (s)
      3'd0:    glyph = 7'h78;
      3'd1:    glyph = 7'h46;
      3'd2:    glyph = 7'h36;
      3'd3:    glyph = 7'h2C;
      default: glyph = BLANK;
    endcase
  endfunction

  logic [9:0]    tgt;
  logic [9:0]    disp_val;
  logic [TW-1:0] tick;
  logic          first_load;

  assign tgt = (credits > 10'd999) ? 10'd999 : credits;

  // Decreases snap, increases creep up one step per tick wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val   <= '0;
      tick       <= '0;
      counting   <= 1'b0;
      first_load <= 1'b1;
    end else if (first_load) begin
      disp_val   <= tgt;
      tick       <= '0;
      counting   <= 1'b0;
      first_load <= 1'b0;
    end else begin
      counting <= (disp_val < tgt);
      if (tgt < disp_val) begin
        disp_val <= tgt;
        tick     <= '0;
      end else if (tgt > disp_val) begin
        if (tick == TICK_LAST) begin
          tick     <= '0;
          disp_val <= disp_val + 10'd1;
        end else begin
          tick <= tick + TW'(1);
        end
      end else begin
        tick <= '0;
      end
    end
  end

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t      state;
  logic [9:0]  conv_src;
  logic [9:0]  conv_sh;
  logic [11:0] bcd;
  logic [11:0] bcd_adj;
  logic [3:0]  iter;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
    assign bcd_adj[gi*4 +: 4] = (bcd[gi*4 +: 4] >= 4'd5) ? bcd[gi*4 +: 4] + 4'd3
                                                          : bcd[gi*4 +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      conv_src <= '0;
      conv_sh  <= '0;
      bcd      <= '0;
      iter     <= '0;
      hex2     <= BLANK;
      hex1     <= BLANK;
      hex0     <= 7'h40;
    end else begin
      case (state)
        IDLE: begin
          if (disp_val != conv_src) begin
            conv_src <= disp_val;
            conv_sh  <= disp_val;
            bcd      <= '0;
            iter     <= 4'd9;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd     <= {bcd_adj[10:0], conv_sh[9]};
          conv_sh <= {conv_sh[8:0], 1'b0};
          if (iter == 4'd0) state <= LOAD;
          else              iter  <= iter - 4'd1;
        end
        LOAD: begin
          hex2  <= (bcd[11:8] == 4'd0) ? BLANK : digit_seg(bcd[11:8]);
          hex1  <= (bcd[11:4] == 8'd0) ? BLANK : digit_seg(bcd[7:4]);
          hex0  <= digit_seg(bcd[3:0]);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex5 <= BLANK;
      hex4 <= BLANK;
      hex3 <= BLANK;
    end else begin
      hex5 <= glyph(symbol_left);
      hex4 <= glyph(symbol_right);
      hex3 <= (bet >= 4'd1 && bet <= 4'd9) ? digit_seg(bet) : BLANK;
    end
  end

endmodule

// File: tb/tb_credit_display_driver.sv
// Scoreboarded bench for credit_display_driver with a short tick period.
module tb_credit_display_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] credits;
  logic [3:0] bet;
  logic [2:0] symbol_left, symbol_right;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
  logic       counting;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          at;
    int          val;
    logic [20:0] exp;
  } sb_t;
  sb_t sb[$];

  logic [20:0] obs;
  assign obs = {hex2, hex1, hex0};

  credit_display_driver #(.TICK_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .credits(credits), .bet(bet),
    .symbol_left(symbol_left), .symbol_right(symbol_right),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .counting(counting)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  function automatic logic [20:0] triple(input int v);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    return {(h == 0) ? 7'h7F : seg(h), (h == 0 && t == 0) ? 7'h7F : seg(t), seg(o)};
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    sb_t e;
    rst_n = 1'b0; credits = 10'd100; bet = 4'd1; symbol_left = 3'd0; symbol_right = 3'd1;
    repeat (3) @(negedge clk);
    total++;
    if ({hex5, hex4, hex3, hex2, hex1, hex0, counting} !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got %h/%h/%h/%h/%h/%h c=%b want 7f/7f/7f/7f/7f/40 c=0",
               hex5, hex4, hex3, hex2, hex1, hex0, counting);
    end
    rst_n = 1'b1;
    sb.push_back('{13, 100, triple(100)});
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1) begin
        total++;
        if ({hex5, hex4, hex3} !== {7'h78, 7'h46, 7'h79}) begin
          bad++;
          $display("FAIL reset_glyphs: got %h/%h/%h want 78/46/79", hex5, hex4, hex3);
        end
      end
      if (k == 12) begin
        total++;
        if (obs !== {7'h7F, 7'h7F, 7'h40}) begin
          bad++;
          $display("FAIL reset_early_load: got %h want %h", obs, {7'h7F, 7'h7F, 7'h40});
        end
      end
      total++;
      if (counting !== 1'b0) begin
        bad++;
        $display("FAIL reset_counting edge %0d: got %b want 0", k, counting);
      end
      if (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL reset_display edge %0d: got %h want %h", k, obs, e.exp);
        end
        $display("txn reset: edge %0d value %0d hex=%h", k, e.val, obs);
      end
    end
  endtask

  task automatic test_decrease;
    sb_t e;
    credits = 10'd99;
    sb.push_back('{13, 99, triple(99)});
    for (int k = 1; k <= 14; k++) begin
      step();
      total++;
      if (counting !== 1'b0) begin
        bad++;
        $display("FAIL decrease_counting edge %0d: got %b want 0", k, counting);
      end
      if (k == 12) begin
        total++;
        if (obs !== triple(100)) begin
          bad++;
          $display("FAIL decrease_early edge 12: got %h want %h", obs, triple(100));
        end
      end
      if (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL decrease_display edge %0d: got %h want %h", k, obs, e.exp);
        end
        $display("txn decrease: edge %0d value %0d hex=%h", k, e.val, obs);
      end
    end
  endtask

  task automatic test_count_up;
    sb_t e;
    logic exp_c;
    credits = 10'd98;
    sb.push_back('{13, 98, triple(98)});
    for (int k = 1; k <= 14; k++) begin
      step();
      if (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL countup_start edge %0d: got %h want %h", k, obs, e.exp);
        end
        $display("txn countup: edge %0d value %0d hex=%h", k, e.val, obs);
      end
    end
    credits = 10'd103;
    sb.push_back('{16, 99, triple(99)});
    sb.push_back('{28, 102, triple(102)});
    sb.push_back('{40, 103, triple(103)});
    for (int k = 1; k <= 44; k++) begin
      step();
      exp_c = (k <= 20);
      total++;
      if (counting !== exp_c) begin
        bad++;
        $display("FAIL countup_counting edge %0d: got %b want %b", k, counting, exp_c);
      end
      if (k == 27) begin
        total++;
        if (obs !== triple(99)) begin
          bad++;
          $display("FAIL countup_hold edge 27: got %h want %h", obs, triple(99));
        end
      end
      if (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL countup_display edge %0d: got %h want %h", k, obs, e.exp);
        end
        $display("txn countup: edge %0d value %0d hex=%h", k, e.val, obs);
      end
    end
  endtask

  task automatic test_clamp;
    sb_t e;
    credits = 10'd1023;
    repeat (6) step();
    total++;
    if (counting !== 1'b1) begin
      bad++;
      $display("FAIL clamp_counting_before_reset: got %b want 1", counting);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({obs, counting} !== {7'h7F, 7'h7F, 7'h40, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: got %h c=%b want 7f7f40 c=0", obs, counting);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{13, 999, triple(999)});
    for (int k = 1; k <= 14; k++) begin
      step();
      total++;
      if (counting !== 1'b0) begin
        bad++;
        $display("FAIL clamp_counting edge %0d: got %b want 0", k, counting);
      end
      if (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL clamp_display edge %0d: got %h want %h", k, obs, e.exp);
        end
        $display("txn clamp: edge %0d value %0d hex=%h", k, e.val, obs);
      end
    end
  endtask

  task automatic test_zero_blank;
    sb_t e;
    logic [3:0]  bets [4] = '{4'd0, 4'd10, 4'd9, 4'd15};
    logic [2:0]  sls  [4] = '{3'd5, 3'd3, 3'd1, 3'd2};
    logic [2:0]  srs  [4] = '{3'd2, 3'd7, 3'd0, 3'd3};
    logic [20:0] exps [4] = '{{7'h7F, 7'h7F, 7'h36}, {7'h7F, 7'h2C, 7'h7F},
                              {7'h10, 7'h46, 7'h78}, {7'h7F, 7'h36, 7'h2C}};
    int vals [2] = '{5, 0};
    for (int p = 0; p < 2; p++) begin
      credits = 10'(vals[p]);
      sb.push_back('{13, vals[p], triple(vals[p])});
      for (int k = 1; k <= 14; k++) begin
        step();
        if (sb.size() > 0 && sb[0].at == k) begin
          e = sb.pop_front();
          total++;
          if (obs !== e.exp) begin
            bad++;
            $display("FAIL zero_display value %0d: got %h want %h", e.val, obs, e.exp);
          end
          $display("txn zero: edge %0d value %0d hex=%h", k, e.val, obs);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      bet = bets[i]; symbol_left = sls[i]; symbol_right = srs[i];
      step();
      total++;
      if ({hex3, hex5, hex4} !== exps[i]) begin
        bad++;
        $display("FAIL glyph_%0d: got %h/%h/%h want %h", i, hex3, hex5, hex4, exps[i]);
      end
      $display("txn glyph: bet %0d left %0d right %0d hex3/5/4=%h/%h/%h",
               bets[i], sls[i], srs[i], hex3, hex5, hex4);
    end
  endtask

  task automatic test_snap_mid_anim;
    sb_t e;
    logic exp_c;
    credits = 10'd100;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) step();
    total++;
    if (obs !== triple(100)) begin
      bad++;
      $display("FAIL snap_setup: got %h want %h", obs, triple(100));
    end
    credits = 10'd110;
    sb.push_back('{16, 101, triple(101)});
    sb.push_back('{28, 104, triple(104)});
    sb.push_back('{40, 50, triple(50)});
    for (int k = 1; k <= 44; k++) begin
      step();
      exp_c = (k <= 20);
      total++;
      if (counting !== exp_c) begin
        bad++;
        $display("FAIL snap_counting edge %0d: got %b want %b", k, counting, exp_c);
      end
      if (k == 39) begin
        total++;
        if (obs !== triple(104)) begin
          bad++;
          $display("FAIL snap_inflight edge 39: got %h want %h", obs, triple(104));
        end
      end
      if (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL snap_display edge %0d: got %h want %h", k, obs, e.exp);
        end
        $display("txn snap: edge %0d value %0d hex=%h", k, e.val, obs);
      end
      if (k == 20) credits = 10'd50;
    end
  endtask

  initial begin
    test_reset();
    test_decrease();
    test_count_up();
    test_clamp();
    test_zero_blank();
    test_snap_mid_anim();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
